cu_fsm: RTL and testbench

Multicycle control-unit state machine for the OTTER RV32I core. It sequences fetch, execute, writeback and interrupt entry, and generates every write and read enable for the PC, register file, CSR file and memory. It adds a ready/ack handshake on both memory ports with a timeout fault, and latches and gates external interrupts. It runs alongside the combinational decoder, supplying it with int_taken.

---
 rtl/cu_pkg.sv | 57 +++++
 rtl/cu_fsm_if.sv | 36 +++
 rtl/cu_fsm_mem_wait_timer.sv | 37 +++
 rtl/cu_fsm.sv | 162 ++++++++++++++++
 tb/tb_cu_fsm.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared types and encodings for the OTTER multicycle control unit and its decoder.
package cu_pkg;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;

    typedef enum logic [2:0] {
        S_INIT,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_INTR,
        S_FAULT
    } cu_state_t;

    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_SYS    = 7'b1110011;
    localparam logic [OPC_W-1:0] OP_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

    localparam logic [F3_W-1:0] F3_MRET  = 3'b000;
    localparam logic [F3_W-1:0] F3_CSRRW = 3'b001;
    localparam logic [F3_W-1:0] F3_CSRRS = 3'b010;
    localparam logic [F3_W-1:0] F3_CSRRC = 3'b011;

    // Per-cycle enables produced by the control FSM; bus_err is kept separately as it is registered.
    typedef struct packed {
        logic pc_we;
        logic rf_we;
        logic mem_rden1;
        logic mem_rden2;
        logic mem_we2;
        logic csr_we;
        logic int_taken;
        logic mret_exec;
        logic rst;
        logic illegal;
    } cu_ctrl_t;

    // Instructions that only write rd and advance the PC.
    function automatic logic is_rf_op(input logic [OPC_W-1:0] op);
        return (op == OP_OP)  || (op == OP_IMM)   || (op == OP_LUI) ||
               (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    // CSR read-modify-write forms with a register source.
    function automatic logic is_csr_f3(input logic [F3_W-1:0] f3);
        return (f3 == F3_CSRRW) || (f3 == F3_CSRRS) || (f3 == F3_CSRRC);
    endfunction

endpackage

// File: rtl/cu_fsm_if.sv
// Handshake and enable signals between the control unit (master) and the core datapath/memories (slave).
interface cu_fsm_if;
    import cu_pkg::*;

    logic             INTR;
    logic             CSR_MIE;
    logic [OPC_W-1:0] opcode;
    logic [F3_W-1:0]  funct3;
    logic             IMEM_ACK;
    logic             DMEM_ACK;

    logic PC_WE;
    logic RF_WE;
    logic memRDEN1;
    logic memRDEN2;
    logic memWE2;
    logic csr_WE;
    logic int_taken;
    logic mret_exec;
    logic rst;
    logic illegal;
    logic bus_err;

    modport master (
        input  INTR, CSR_MIE, opcode, funct3, IMEM_ACK, DMEM_ACK,
        output PC_WE, RF_WE, memRDEN1, memRDEN2, memWE2, csr_WE,
               int_taken, mret_exec, rst, illegal, bus_err
    );

    modport slave (
        output INTR, CSR_MIE, opcode, funct3, IMEM_ACK, DMEM_ACK,
        input  PC_WE, RF_WE, memRDEN1, memRDEN2, memWE2, csr_WE,
               int_taken, mret_exec, rst, illegal, bus_err
    );

endinterface

// File: rtl/cu_fsm_mem_wait_timer.sv
// Counts cycles a memory request waits for its ack; flags the last permitted waiting cycle.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic ack,
    input  logic clear,
    output logic expired
);

    // expired fires on the cycle whose increment would make the count equal MEM_TIMEOUT.
    localparam logic [CNT_W-1:0] LAST =
        CNT_W'((MEM_TIMEOUT == 32'd0) ? 32'd0 : (MEM_TIMEOUT - 32'd1));

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || ack) begin
            cnt <= '0;
        end else if (busy && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        expired = 1'b0;
        if ((MEM_TIMEOUT != 32'd0) && busy && !ack && (cnt == LAST)) begin
            expired = 1'b1;
        end
    end

endmodule

// File: rtl/cu_fsm.sv
// OTTER multicycle control unit: fetch/execute/writeback/interrupt sequencing with memory handshake timeout.
module cu_fsm
    import cu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic      CLK,
    input  logic      RST,
    cu_fsm_if.master  bus
);

    cu_state_t state;
    cu_state_t state_next;
    cu_state_t boundary_state;
    cu_ctrl_t  ctrl;
    logic      intr_pend;
    logic      bus_err_q;
    logic      take_int;
    logic      wait_busy;
    logic      wait_ack;
    logic      wait_clear;
    logic      wait_expired;

    // Interrupt is taken at an instruction boundary; a request arriving in that very cycle counts.
    assign take_int       = (intr_pend | bus.INTR) & bus.CSR_MIE;
    assign boundary_state = take_int ? S_INTR : S_FETCH;
    assign wait_clear     = (state_next != state);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait (
        .clk     (CLK),
        .rst     (RST),
        .busy    (wait_busy),
        .ack     (wait_ack),
        .clear   (wait_clear),
        .expired (wait_expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_INIT;
            intr_pend <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_next;
            intr_pend <= bus.INTR | (intr_pend & (state != S_INTR));
            bus_err_q <= bus_err_q | (state_next == S_FAULT);
        end
    end

    always_comb begin
        state_next = state;
        ctrl       = '0;
        wait_busy  = 1'b0;
        wait_ack   = 1'b0;

        unique case (state)
            S_INIT: begin
                ctrl.rst   = 1'b1;
                state_next = S_FETCH;
            end

            S_FETCH: begin
                ctrl.mem_rden1 = 1'b1;
                wait_busy      = 1'b1;
                wait_ack       = bus.IMEM_ACK;
                if (bus.IMEM_ACK) begin
                    state_next = S_EXEC;
                end else if (wait_expired) begin
                    state_next = S_FAULT;
                end
            end

            S_EXEC: begin
                if (bus.opcode == OP_LOAD) begin
                    ctrl.mem_rden2 = 1'b1;
                    wait_busy      = 1'b1;
                    wait_ack       = bus.DMEM_ACK;
                    if (bus.DMEM_ACK) begin
                        state_next = S_WB;
                    end else if (wait_expired) begin
                        state_next = S_FAULT;
                    end
                end else if (bus.opcode == OP_STORE) begin
                    ctrl.mem_we2 = 1'b1;
                    wait_busy    = 1'b1;
                    wait_ack     = bus.DMEM_ACK;
                    if (bus.DMEM_ACK) begin
                        ctrl.pc_we = 1'b1;
                        state_next = boundary_state;
                    end else if (wait_expired) begin
                        state_next = S_FAULT;
                    end
                end else if (bus.opcode == OP_BRANCH) begin
                    ctrl.pc_we = 1'b1;
                    state_next = boundary_state;
                end else if (bus.opcode == OP_SYS) begin
                    ctrl.pc_we = 1'b1;
                    if (bus.funct3 == F3_MRET) begin
                        ctrl.mret_exec = 1'b1;
                    end else if (is_csr_f3(bus.funct3)) begin
                        ctrl.csr_we = 1'b1;
                        ctrl.rf_we  = 1'b1;
                    end
                    state_next = boundary_state;
                end else if (is_rf_op(bus.opcode)) begin
                    ctrl.rf_we = 1'b1;
                    ctrl.pc_we = 1'b1;
                    state_next = boundary_state;
                end else begin
                    // Unknown opcode retires as a NOP so software can still make progress.
                    ctrl.illegal = 1'b1;
                    ctrl.pc_we   = 1'b1;
                    state_next   = boundary_state;
                end
            end

            S_WB: begin
                ctrl.rf_we = 1'b1;
                ctrl.pc_we = 1'b1;
                state_next = boundary_state;
            end

            S_INTR: begin
                ctrl.int_taken = 1'b1;
                ctrl.pc_we     = 1'b1;
                state_next     = S_FETCH;
            end

            S_FAULT: begin
                state_next = S_FAULT;
            end

            default: begin
                state_next = S_INIT;
            end
        endcase

        // Reset drops every request combinationally so no partial access escapes.
        if (RST) begin
            ctrl      = '0;
            wait_busy = 1'b0;
            wait_ack  = 1'b0;
        end
    end

    assign bus.PC_WE     = ctrl.pc_we;
    assign bus.RF_WE     = ctrl.rf_we;
    assign bus.memRDEN1  = ctrl.mem_rden1;
    assign bus.memRDEN2  = ctrl.mem_rden2;
    assign bus.memWE2    = ctrl.mem_we2;
    assign bus.csr_WE    = ctrl.csr_we;
    assign bus.int_taken = ctrl.int_taken;
    assign bus.mret_exec = ctrl.mret_exec;
    assign bus.rst       = ctrl.rst;
    assign bus.illegal   = ctrl.illegal;
    assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_cu_fsm.sv
// Directed cycle-by-cycle bench for cu_fsm; every output cycle is compared against a hand-derived enable vector.
module tb_cu_fsm;

    localparam logic [10:0] E_NONE = 11'b000_0000_0000;
    localparam logic [10:0] E_PC   = 11'b100_0000_0000;
    localparam logic [10:0] E_RF   = 11'b010_0000_0000;
    localparam logic [10:0] E_RD1  = 11'b001_0000_0000;
    localparam logic [10:0] E_RD2  = 11'b000_1000_0000;
    localparam logic [10:0] E_WE2  = 11'b000_0100_0000;
    localparam logic [10:0] E_CSR  = 11'b000_0010_0000;
    localparam logic [10:0] E_INT  = 11'b000_0001_0000;
    localparam logic [10:0] E_MRET = 11'b000_0000_1000;
    localparam logic [10:0] E_RST  = 11'b000_0000_0100;
    localparam logic [10:0] E_ILL  = 11'b000_0000_0010;
    localparam logic [10:0] E_BERR = 11'b000_0000_0001;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_SYS   = 7'b1110011;
    localparam logic [6:0] OPC_ADDI  = 7'b0010011;
    localparam logic [6:0] OPC_BAD   = 7'b1111111;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cu_fsm_if bus_if ();

    cu_fsm #(
        .MEM_TIMEOUT (16),
        .CNT_W       (5)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus_if)
    );

    logic [10:0] outs;
    assign outs = {bus_if.PC_WE, bus_if.RF_WE, bus_if.memRDEN1, bus_if.memRDEN2,
                   bus_if.memWE2, bus_if.csr_WE, bus_if.int_taken, bus_if.mret_exec,
                   bus_if.rst, bus_if.illegal, bus_if.bus_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%011b exp=%011b", tag, got, exp);
        end
    endtask

    // Inputs are set just after a rising edge; outputs are checked at the following falling edge.
    task automatic tick(input string tag, input logic [10:0] exp);
        #4;
        chk(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch1(input string tag);
        bus_if.IMEM_ACK = 1'b1;
        tick(tag, E_RD1);
        bus_if.IMEM_ACK = 1'b0;
    endtask

    task automatic exec(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [10:0] exp);
        bus_if.opcode = op;
        bus_if.funct3 = f3;
        tick(tag, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst               = 1'b1;
        bus_if.INTR       = 1'b0;
        bus_if.CSR_MIE    = 1'b1;
        bus_if.opcode     = OPC_ADDI;
        bus_if.funct3     = 3'b000;
        bus_if.IMEM_ACK   = 1'b0;
        bus_if.DMEM_ACK   = 1'b0;

        @(posedge clk);
        #1;
        tick("reset_hold", E_NONE);
        rst = 1'b0;
        tick("init", E_RST);

        // ADDI with a two-cycle fetch stall
        bus_if.opcode = OPC_ADDI;
        tick("addi_f0", E_RD1);
        tick("addi_f1", E_RD1);
        fetch1("addi_f2");
        exec("addi_x", OPC_ADDI, 3'b000, E_RF | E_PC);

        // LW with a three-cycle data stall, then writeback
        fetch1("lw_f");
        bus_if.opcode   = OPC_LOAD;
        bus_if.DMEM_ACK = 1'b0;
        tick("lw_x0", E_RD2);
        tick("lw_x1", E_RD2);
        tick("lw_x2", E_RD2);
        bus_if.DMEM_ACK = 1'b1;
        tick("lw_x3", E_RD2);
        bus_if.DMEM_ACK = 1'b0;
        tick("lw_wb", E_RF | E_PC);

        // Interrupt pulse during fetch is taken at the next boundary, once
        bus_if.INTR = 1'b1;
        fetch1("irq_f");
        bus_if.INTR = 1'b0;
        exec("irq_x", OPC_ADDI, 3'b000, E_RF | E_PC);
        tick("irq_take", E_INT | E_PC);
        fetch1("irq_f2");
        exec("irq_x2", OPC_ADDI, 3'b000, E_RF | E_PC);

        // A new pulse arriving in the INTR cycle survives the pending clear
        bus_if.INTR = 1'b1;
        fetch1("rearm_f");
        bus_if.INTR = 1'b0;
        exec("rearm_x", OPC_ADDI, 3'b000, E_RF | E_PC);
        bus_if.INTR = 1'b1;
        tick("rearm_take1", E_INT | E_PC);
        bus_if.INTR = 1'b0;
        fetch1("rearm_f2");
        exec("rearm_x2", OPC_ADDI, 3'b000, E_RF | E_PC);
        tick("rearm_take2", E_INT | E_PC);

        // Interrupt held pending while MIE is clear, taken once after it is set
        bus_if.CSR_MIE = 1'b0;
        bus_if.INTR    = 1'b1;
        fetch1("mie0_f");
        bus_if.INTR    = 1'b0;
        exec("mie0_x", OPC_ADDI, 3'b000, E_RF | E_PC);
        for (int i = 0; i < 5; i++) begin
            fetch1("mie0_loop_f");
            exec("mie0_loop_x", OPC_ADDI, 3'b000, E_RF | E_PC);
        end
        bus_if.CSR_MIE = 1'b1;
        fetch1("mie1_f");
        exec("mie1_x", OPC_ADDI, 3'b000, E_RF | E_PC);
        tick("mie1_take", E_INT | E_PC);
        fetch1("mie1_f2");
        exec("mie1_x2", OPC_ADDI, 3'b000, E_RF | E_PC);

        // Illegal opcode, mret, CSR write, branch, other SYSTEM funct3
        fetch1("ill_f");
        exec("ill_x", OPC_BAD, 3'b000, E_ILL | E_PC);
        fetch1("mret_f");
        exec("mret_x", OPC_SYS, 3'b000, E_MRET | E_PC);
        fetch1("csrrw_f");
        exec("csrrw_x", OPC_SYS, 3'b001, E_CSR | E_RF | E_PC);
        fetch1("br_f");
        exec("br_x", OPC_BR, 3'b000, E_PC);
        fetch1("sys_f");
        exec("sys100_x", OPC_SYS, 3'b100, E_PC);

        // Stray data ack during fetch is ignored; store waits one cycle for its ack
        bus_if.DMEM_ACK = 1'b1;
        tick("stray_ack", E_RD1);
        bus_if.DMEM_ACK = 1'b0;
        fetch1("sw_f");
        exec("sw_x0", OPC_STORE, 3'b010, E_WE2);
        bus_if.DMEM_ACK = 1'b1;
        tick("sw_x1", E_WE2 | E_PC);
        bus_if.DMEM_ACK = 1'b0;

        // Instruction fetch never acked: 16 waiting cycles, then sticky fault
        bus_if.opcode = OPC_ADDI;
        for (int i = 0; i < 16; i++) begin
            tick("to_wait", E_RD1);
        end
        bus_if.IMEM_ACK = 1'b1;
        tick("fault", E_BERR);
        tick("fault_hold", E_BERR);
        bus_if.IMEM_ACK = 1'b0;

        // Reset clears the fault
        rst = 1'b1;
        tick("rst_fault", E_NONE);
        rst = 1'b0;
        tick("init2", E_RST);

        // Reset in the middle of a fetch drops the request immediately
        tick("mid_f0", E_RD1);
        tick("mid_f1", E_RD1);
        rst = 1'b1;
        tick("rst_mid", E_NONE);
        rst = 1'b0;
        tick("init3", E_RST);
        fetch1("post_f");
        exec("post_x", OPC_ADDI, 3'b000, E_RF | E_PC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
